// File: rtl/i2s_rcvr_frame_cntlr_if.sv
// Sample-pair handshake between the I2S receive frame controller and its
// downstream consumer. The controller drives the master side.
interface i2s_rcvr_frame_cntlr_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] left_data;
   logic [WIDTH-1:0] right_data;
   logic             sample_valid;
   logic             sample_ready;
   logic             overrun;

   modport master (
      output left_data,
      output right_data,
      output sample_valid,
      output overrun,
      input  sample_ready
   );

   modport slave (
      input  left_data,
      input  right_data,
      input  sample_valid,
      input  overrun,
      output sample_ready
   );
endinterface

// File: rtl/i2s_rcvr_frame_cntlr.sv
// I2S receive frame controller: oversamples SCK/WS/SD on clk, shifts each
// channel word MSB-first with the one-bit I2S delay, zero-pads short slots,
// truncates long slots, and presents stereo pairs over valid/ready.
// Optional macro I2S_RCVR_OVERRUN_EN: drop new pairs while a presented pair
// is stalled and flag it on a sticky overrun output; without it a new pair
// overwrites the presented one and overrun stays 0.
module i2s_rcvr_frame_cntlr #(
   parameter int WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   n_rst,
   input  logic                   sck_in,
   input  logic                   ws_in,
   input  logic                   sd_in,
   i2s_rcvr_frame_cntlr_if.master smp
);
   localparam int              CW      = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]   WIDTH_C = CW'(WIDTH);

   typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

   logic [1:0]       sck_sync;
   logic [1:0]       ws_sync;
   logic [1:0]       sd_sync;
   logic             sck_prev;
   logic             rise;
   logic             ws_smp;
   logic             sd_smp;
   logic             ws_last;

   state_t           state;
   logic             chan;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] left_hold;
   logic             left_pend;

   logic [WIDTH-1:0] left_data_reg;
   logic [WIDTH-1:0] right_data_reg;
   logic             valid_reg;

   logic             ws_chg;
   logic [WIDTH-1:0] shreg_in;
   logic [CW-1:0]    cnt_fin;
   logic [WIDTH-1:0] word;
   logic             commit;
   logic             pair_form;
   logic             xfer;

   // Two-flop synchronizers, then a registered SCK rise pulse with ws/sd
   // captured in the same cycle so they line up with the pulse.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         sck_sync <= '0;
         ws_sync  <= '0;
         sd_sync  <= '0;
         sck_prev <= 1'b0;
         rise     <= 1'b0;
         ws_smp   <= 1'b0;
         sd_smp   <= 1'b0;
      end else begin
         sck_sync <= {sck_sync[0], sck_in};
         ws_sync  <= {ws_sync[0], ws_in};
         sd_sync  <= {sd_sync[0], sd_in};
         sck_prev <= sck_sync[1];
         rise     <= sck_sync[1] & ~sck_prev;
         ws_smp   <= ws_sync[1];
         sd_smp   <= sd_sync[1];
      end
   end

   // Word that would be committed at this rise: in SHIFT the current bit is
   // the ending word's LSB; the result is left-aligned so short slots pad.
   always_comb begin
      ws_chg   = ws_smp ^ ws_last;
      shreg_in = {shreg[WIDTH-2:0], sd_smp};
      cnt_fin  = cnt;
      word     = shreg;
      if (state == SHIFT) begin
         cnt_fin = cnt + CW'(1);
         word    = shreg_in << (WIDTH_C - cnt_fin);
      end
      commit    = rise && ws_chg && (state != IDLE);
      pair_form = commit && chan && left_pend;
      xfer      = valid_reg && smp.sample_ready;
   end

   // Slot sequencer: sync on a ws change, shift up to WIDTH bits, hold the
   // rest, and commit left/right words at each ws change.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state     <= IDLE;
         chan      <= 1'b0;
         cnt       <= '0;
         shreg     <= '0;
         left_hold <= '0;
         left_pend <= 1'b0;
         ws_last   <= 1'b0;
      end else if (rise) begin
         ws_last <= ws_smp;
         if (ws_chg) begin
            // The bit at a resync rise belongs to the previous slot.
            state <= SHIFT;
            chan  <= ws_smp;
            cnt   <= '0;
            shreg <= '0;
            if (state != IDLE) begin
               if (!chan) begin
                  left_hold <= word;
                  left_pend <= 1'b1;
               end else begin
                  left_pend <= 1'b0;
               end
            end
         end else if (state == SHIFT) begin
            shreg <= shreg_in;
            cnt   <= cnt + CW'(1);
            if (cnt + CW'(1) == WIDTH_C) begin
               state <= HOLD;
            end
         end
      end
   end

`ifdef I2S_RCVR_OVERRUN_EN
   logic overrun_reg;

   // Present pairs; a pair arriving against a stalled one is dropped and
   // flagged until the next completed transfer.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         left_data_reg  <= '0;
         right_data_reg <= '0;
         valid_reg      <= 1'b0;
         overrun_reg    <= 1'b0;
      end else if (pair_form && (!valid_reg || smp.sample_ready)) begin
         left_data_reg  <= left_hold;
         right_data_reg <= word;
         valid_reg      <= 1'b1;
         if (xfer) begin
            overrun_reg <= 1'b0;
         end
      end else if (pair_form) begin
         overrun_reg <= 1'b1;
      end else if (xfer) begin
         valid_reg   <= 1'b0;
         overrun_reg <= 1'b0;
      end
   end

   assign smp.overrun = overrun_reg;
`else
   // Present pairs; a newer pair always replaces the presented one.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         left_data_reg  <= '0;
         right_data_reg <= '0;
         valid_reg      <= 1'b0;
      end else if (pair_form) begin
         left_data_reg  <= left_hold;
         right_data_reg <= word;
         valid_reg      <= 1'b1;
      end else if (xfer) begin
         valid_reg <= 1'b0;
      end
   end

   assign smp.overrun = 1'b0;
`endif

   assign smp.left_data    = left_data_reg;
   assign smp.right_data   = right_data_reg;
   assign smp.sample_valid = valid_reg;

endmodule
